// File: rtl/lfsr_stream_checker.sv
// Stream monitor for the 4-bit LFSR generator: acquires lock on the next-state rule,
// then flags mismatches, measures the sequence period and detects stuck samples.
module lfsr_stream_checker #(
  parameter int SYNC_N     = 3,
  parameter int MISS_LIMIT = 2,
  parameter int STUCK_N    = 4,
  parameter int ERR_W      = 8,
  parameter int PER_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       num,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             stuck
);

  localparam int MW  = $clog2(SYNC_N + 1);
  localparam int XW  = $clog2(MISS_LIMIT + 1);
  localparam int SW  = $clog2(STUCK_N);
  localparam logic [MW-1:0] SYNC_V   = MW'(SYNC_N);
  localparam logic [XW-1:0] MISS_V   = XW'(MISS_LIMIT);
  localparam logic [SW-1:0] SAME_MAX = SW'(STUCK_N - 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_e;

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    logic x;
    x = s[0] ^ s[1];
    return {x, ~(s[3] ^ x), s[2], s[1]};
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       last_q, last_d;
  logic [3:0]       anchor_q, anchor_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [XW-1:0]    miss_cnt_q, miss_cnt_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [SW-1:0]    same_cnt_q, same_cnt_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [PER_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             stuck_q, stuck_d;

  logic             match;
  logic [MW-1:0]    match_inc;
  logic [XW-1:0]    miss_inc;
  logic [SW-1:0]    same_next;
  logic             drop;

  // A repeated sample is never a match, which keeps the 0111 lockup state from locking.
  assign match     = (num == lfsr_next(last_q)) && (num != last_q);
  assign match_inc = match_cnt_q + MW'(1);
  assign miss_inc  = miss_cnt_q + XW'(1);
  assign same_next = (same_cnt_q == SAME_MAX) ? same_cnt_q : same_cnt_q + SW'(1);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d        = state_q;
    last_d         = last_q;
    anchor_d       = anchor_q;
    match_cnt_d    = match_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    per_cnt_d      = per_cnt_q;
    same_cnt_d     = same_cnt_q;
    err_d          = 1'b0;
    err_count_d    = err_count_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    stuck_d        = stuck_q;
    drop           = 1'b0;

    if (en) begin
      last_d = num;

      if (num == last_q) begin
        same_cnt_d = same_next;
        stuck_d    = (same_next == SAME_MAX);
      end else begin
        same_cnt_d = '0;
        stuck_d    = 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          match_cnt_d = '0;
          state_d     = ACQUIRE;
        end

        ACQUIRE: begin
          if (match) begin
            match_cnt_d = match_inc;
            if (match_inc == SYNC_V) begin
              state_d    = LOCKED;
              anchor_d   = num;
              per_cnt_d  = '0;
              miss_cnt_d = '0;
            end
          end else begin
            match_cnt_d = '0;
          end
        end

        LOCKED: begin
          if (match) begin
            miss_cnt_d = '0;
          end else begin
            err_d       = 1'b1;
            err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + ERR_W'(1);
            miss_cnt_d  = miss_inc;
            if (miss_inc == MISS_V) begin
              drop        = 1'b1;
              state_d     = ACQUIRE;
              match_cnt_d = '0;
            end
          end

          // Anchor hits only count on a correct prediction, so err and period_valid never coincide.
          if (!drop) begin
            if (match && (num == anchor_q)) begin
              period_d       = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + PER_W'(1);
              period_valid_d = 1'b1;
              per_cnt_d      = '0;
            end else begin
              per_cnt_d = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + PER_W'(1);
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      last_q         <= '0;
      anchor_q       <= '0;
      match_cnt_q    <= '0;
      miss_cnt_q     <= '0;
      per_cnt_q      <= '0;
      same_cnt_q     <= '0;
      err_q          <= 1'b0;
      err_count_q    <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      stuck_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      anchor_q       <= anchor_d;
      match_cnt_q    <= match_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      per_cnt_q      <= per_cnt_d;
      same_cnt_q     <= same_cnt_d;
      err_q          <= err_d;
      err_count_q    <= err_count_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      stuck_q        <= stuck_d;
    end
  end

  assign locked       = (state_q == LOCKED);
  assign err          = err_q;
  assign err_count    = err_count_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign stuck        = stuck_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Randomized bench for lfsr_stream_checker: a sample-level model predicts every output
// cycle by cycle, and directed scenarios pin the model with hand-derived values.
module tb_lfsr_stream_checker;

  localparam int SYNC_N     = 3;
  localparam int MISS_LIMIT = 2;
  localparam int STUCK_N    = 4;
  localparam int ERR_W      = 8;
  localparam int PER_W      = 5;
  localparam int ERR_MAX    = (1 << ERR_W) - 1;
  localparam int PER_MAX    = (1 << PER_W) - 1;

  logic             clk;
  logic             reset;
  logic             en;
  logic [3:0]       num;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic [PER_W-1:0] period;
  logic             period_valid;
  logic             stuck;

  lfsr_stream_checker #(
    .SYNC_N(SYNC_N), .MISS_LIMIT(MISS_LIMIT), .STUCK_N(STUCK_N),
    .ERR_W(ERR_W), .PER_W(PER_W)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .num(num),
    .locked(locked), .err(err), .err_count(err_count), .period(period),
    .period_valid(period_valid), .stuck(stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int gen_seq [6] = '{0, 4, 6, 11, 1, 8};

  // Model state: what the checker has learned about the stream so far.
  int m_started, m_locked, m_last, m_good, m_bad, m_anchor, m_since, m_run;
  int e_locked, e_err, e_cnt, e_period, e_pv, e_stuck;

  function automatic int f(input int s);
    int x;
    x = (s ^ (s >> 1)) & 1;
    return (x << 3) | ((~((s >> 3) ^ x) & 1) << 2) | (((s >> 2) & 1) << 1) | ((s >> 1) & 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_locked = 0; m_last = 0; m_good = 0; m_bad = 0;
    m_anchor = 0; m_since = 0; m_run = 1;
    e_locked = 0; e_err = 0; e_cnt = 0; e_period = 0; e_pv = 0; e_stuck = 0;
  endtask

  task automatic model_sample(input int n);
    bit hit;
    hit = (n == f(m_last)) && (n != m_last);
    e_err = 0;
    e_pv  = 0;
    m_run = (n == m_last) ? ((m_run + 1 > STUCK_N) ? STUCK_N : m_run + 1) : 1;
    e_stuck = (m_run >= STUCK_N);
    if (!m_started) begin
      m_started = 1;
      m_good = 0;
    end else if (!m_locked) begin
      if (hit) begin
        m_good++;
        if (m_good == SYNC_N) begin
          m_locked = 1; m_anchor = n; m_since = 0; m_bad = 0;
        end
      end else m_good = 0;
    end else begin
      if (hit) m_bad = 0;
      else begin
        e_err = 1;
        e_cnt = (e_cnt < ERR_MAX) ? e_cnt + 1 : ERR_MAX;
        m_bad++;
      end
      if (m_bad == MISS_LIMIT) begin
        m_locked = 0; m_good = 0;
      end else if (hit && n == m_anchor) begin
        e_period = (m_since + 1 > PER_MAX) ? PER_MAX : m_since + 1;
        e_pv = 1;
        m_since = 0;
      end else begin
        m_since = (m_since + 1 > PER_MAX) ? PER_MAX : m_since + 1;
      end
    end
    m_last = n;
    e_locked = m_locked;
  endtask

  // Inputs change on the falling edge; the model advances with them.
  task automatic step(input logic r, input logic e, input logic [3:0] n);
    @(negedge clk);
    reset = r; en = e; num = n;
    if (r) model_reset();
    else if (e) model_sample(int'(n));
    else begin e_err = 0; e_pv = 0; end
    chk_en = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("locked", locked, e_locked);
      check("err", err, e_err);
      check("err_count", err_count, e_cnt);
      check("period", period, e_period);
      check("period_valid", period_valid, e_pv);
      check("stuck", stuck, e_stuck);
    end
  end

  function automatic logic [3:0] glitch(input logic [3:0] cand);
    logic [3:0] g;
    g = cand;
    if (m_locked != 0 && int'(g) != f(m_last) && int'(g) == m_anchor) g = g + 4'd1;
    return g;
  endfunction

  task automatic run_lock(input string tag);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 4'(gen_seq[i % 6]));
      if (i == 2) begin settle(); check({tag, "_not_yet_locked"}, locked, 0); end
      if (i == 3) begin settle(); check({tag, "_locked_on_B"}, locked, 1); end
      if (i == 9) begin
        settle();
        check({tag, "_period"}, period, 6);
        check({tag, "_period_valid"}, period_valid, 1);
        check({tag, "_err_count"}, err_count, 0);
      end
    end
  endtask

  initial begin
    logic [3:0] rv;
    int r;
    int iter;
    reset = 1'b1; en = 1'b0; num = 4'd0;
    model_reset();

    check("f_0", f(0), 4);
    check("f_6", f(6), 11);
    check("f_8", f(8), 0);
    check("f_7", f(7), 7);

    // Lock, then single glitch 1->9 followed by the unpredicted 8, then relock.
    step(1'b1, 1'b0, 4'd0);
    run_lock("t1");
    step(1'b0, 1'b1, 4'd9);
    settle();
    check("t2_err1", err, 1); check("t2_cnt1", err_count, 1); check("t2_still_locked", locked, 1);
    step(1'b0, 1'b1, 4'd8);
    settle();
    check("t2_err2", err, 1); check("t2_cnt2", err_count, 2); check("t2_dropped", locked, 0);
    step(1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b1, 4'd4);
    settle(); check("t2_acquiring", locked, 0);
    step(1'b0, 1'b1, 4'd6);
    settle(); check("t2_relocked", locked, 1);

    // Reset mid-lock with err_count=2 clears everything; relock follows the same timing.
    step(1'b1, 1'b0, 4'd0);
    settle();
    check("t6_locked", locked, 0); check("t6_cnt", err_count, 0);
    check("t6_period", period, 0); check("t6_stuck", stuck, 0);
    run_lock("t6");

    // Lockup state 0111 repeated.
    step(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 4'd7);
      settle();
      check("t3_never_locked", locked, 0);
      if (i == 2) check("t3_stuck_3rd", stuck, 0);
      if (i == 3) check("t3_stuck_4th", stuck, 1);
    end
    step(1'b0, 1'b1, 4'd0);
    settle(); check("t3_stuck_cleared", stuck, 0);

    // Strobe gating: period counts samples, not clocks.
    step(1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 4'(gen_seq[k % 6]));
      if (k == 9) begin
        settle();
        check("t4_period", period, 6); check("t4_pv", period_valid, 1); check("t4_cnt", err_count, 0);
      end
      step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
    end

    // Randomized traffic: good streams, glitches, repeats, gaps and occasional resets.
    step(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       step(1'b1, 1'b0, 4'd0);
      else if (r < 15) step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      else if (r < 25) step(1'b0, 1'b1, 4'(m_last));
      else if (r < 33) begin
        rv = glitch(4'($urandom_range(0, 15)));
        step(1'b0, 1'b1, rv);
      end
      else step(1'b0, 1'b1, 4'(f(m_last)));
    end

    // Drive err_count into saturation with lock/glitch rounds.
    step(1'b1, 1'b0, 4'd0);
    iter = 0;
    while (e_cnt < ERR_MAX && iter < 2000) begin
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 4'(f(m_last)));
      for (int k = 0; k < 2; k++) begin
        rv = glitch(4'($urandom_range(0, 15)));
        step(1'b0, 1'b1, rv);
      end
      iter++;
    end
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 4'(f(m_last)));
    step(1'b0, 1'b1, 4'(f(f(m_last))));
    settle();
    check("t5_saturated", err_count, ERR_MAX);
    check("t5_err_on_sat", err, 1);

    step(1'b0, 1'b0, 4'd0);
    settle();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
